// File: rtl/ctrl_decode_exmem.sv
// rtl/ctrl_decode_exmem.sv - instruction control decode plus EX/MEM pipeline register
module ctrl_decode_exmem #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       opcode,
  input  logic              sign,
  output logic              uncondBr,
  output logic              branch,
  output logic              Reg2Loc,
  output logic              ALU_Src,
  output logic              RegWrite,
  output logic              ALU_SH,
  output logic              Imm,
  output logic              memToReg,
  output logic              memWrite,
  output logic              shiftDirn,
  output logic              ALU_on,
  output logic              set_flags,
  output logic              branchReg,
  output logic              branchLink,
  output logic              memRead,
  output logic [1:0]        fwdEn,
  output logic [2:0]        ALU_cntrl,
  input  logic              memToReg_EX,
  input  logic              memWrite_EX,
  input  logic              memRead_EX,
  input  logic              branchLink_EX,
  input  logic              RegWrite_EX,
  input  logic [4:0]        targetReg_EX,
  input  logic [DATA_W-1:0] toDataMem,
  input  logic [DATA_W-1:0] ALU_B,
  input  logic [DATA_W-1:0] rd2_EX,
  input  logic [DATA_W-1:0] memData,
  output logic              memToReg_MEM,
  output logic              memWrite_MEM,
  output logic              memRead_MEM,
  output logic              branchLink_MEM,
  output logic              RegWrite_MEM,
  output logic [4:0]        targetReg_MEM,
  output logic [DATA_W-1:0] toDataMem_MEM,
  output logic [DATA_W-1:0] ALU_B_MEM,
  output logic [DATA_W-1:0] rd2_MEM,
  output logic [DATA_W-1:0] memData_MEM
);

  logic [2:0] alu_sel;

  // Case items are ordered longest pattern first so full opcodes win over prefixes.
  always_comb begin
    uncondBr   = 1'b0;
    branch     = 1'b0;
    Reg2Loc    = 1'b0;
    ALU_Src    = 1'b0;
    RegWrite   = 1'b0;
    ALU_SH     = 1'b0;
    Imm        = 1'b0;
    memToReg   = 1'b0;
    memWrite   = 1'b0;
    shiftDirn  = 1'b0;
    ALU_on     = 1'b0;
    set_flags  = 1'b0;
    branchReg  = 1'b0;
    branchLink = 1'b0;
    memRead    = 1'b0;
    fwdEn      = 2'b00;
    alu_sel    = 3'b000;
    if (rst) begin
      casez (opcode)
        11'b10101011000, 11'b11101011000: begin
          Reg2Loc   = 1'b1;
          RegWrite  = 1'b1;
          ALU_on    = 1'b1;
          set_flags = 1'b1;
          fwdEn     = 2'b11;
          alu_sel   = opcode[9] ? 3'b011 : 3'b010;
        end
        11'b10001010000, 11'b11001010000: begin
          Reg2Loc  = 1'b1;
          RegWrite = 1'b1;
          ALU_on   = 1'b1;
          fwdEn    = 2'b11;
          alu_sel  = opcode[9] ? 3'b110 : 3'b100;
        end
        11'b11010011011, 11'b11010011010: begin
          RegWrite  = 1'b1;
          ALU_SH    = 1'b1;
          shiftDirn = ~opcode[0];
        end
        11'b11111000010: begin
          ALU_Src  = 1'b1;
          RegWrite = 1'b1;
          memToReg = 1'b1;
          memRead  = 1'b1;
          ALU_on   = 1'b1;
          alu_sel  = sign ? 3'b011 : 3'b010;
        end
        11'b11111000000: begin
          ALU_Src  = 1'b1;
          memWrite = 1'b1;
          ALU_on   = 1'b1;
          alu_sel  = sign ? 3'b011 : 3'b010;
        end
        11'b11010110000: begin
          branch    = 1'b1;
          branchReg = 1'b1;
        end
        11'b1001000100?: begin
          ALU_Src  = 1'b1;
          Imm      = 1'b1;
          RegWrite = 1'b1;
          ALU_on   = 1'b1;
          fwdEn    = 2'b10;
          alu_sel  = 3'b010;
        end
        11'b10110100???: begin
          branch = 1'b1;
          ALU_on = 1'b1;
        end
        11'b01010100???: begin
          branch = 1'b1;
        end
        11'b000101?????: begin
          branch   = 1'b1;
          uncondBr = 1'b1;
        end
        11'b100101?????: begin
          branch     = 1'b1;
          uncondBr   = 1'b1;
          branchLink = 1'b1;
          RegWrite   = 1'b1;
          ALU_on     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ALU_cntrl = ALU_on ? alu_sel : 3'b000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memToReg_MEM   <= 1'b0;
      memWrite_MEM   <= 1'b0;
      memRead_MEM    <= 1'b0;
      branchLink_MEM <= 1'b0;
      RegWrite_MEM   <= 1'b0;
      targetReg_MEM  <= 5'd0;
      toDataMem_MEM  <= '0;
      ALU_B_MEM      <= '0;
      rd2_MEM        <= '0;
      memData_MEM    <= '0;
    end else begin
      memToReg_MEM   <= memToReg_EX;
      memWrite_MEM   <= memWrite_EX;
      memRead_MEM    <= memRead_EX;
      branchLink_MEM <= branchLink_EX;
      RegWrite_MEM   <= RegWrite_EX;
      targetReg_MEM  <= targetReg_EX;
      toDataMem_MEM  <= toDataMem;
      ALU_B_MEM      <= ALU_B;
      rd2_MEM        <= rd2_EX;
      memData_MEM    <= memData;
    end
  end

endmodule

// File: tb/tb_ctrl_decode_exmem.sv
// tb/tb_ctrl_decode_exmem.sv - self-checking bench for ctrl_decode_exmem
module tb_ctrl_decode_exmem;
  localparam int DATA_W = 64;
  localparam int PW = 4 * DATA_W + 10;

  localparam logic [14:0] UNC = 15'h4000, BRN = 15'h2000, R2L = 15'h1000,
                          SRC = 15'h0800, RW = 15'h0400, SH = 15'h0200,
                          IMM = 15'h0100, M2R = 15'h0080, MW = 15'h0040,
                          DIR = 15'h0020, ON = 15'h0010, SF = 15'h0008,
                          BRR = 15'h0004, BL = 15'h0002, MRD = 15'h0001;

  logic clk = 1'b0;
  logic rst;
  logic [10:0] opcode;
  logic sign;
  logic uncondBr, branch, Reg2Loc, ALU_Src, RegWrite, ALU_SH, Imm, memToReg;
  logic memWrite, shiftDirn, ALU_on, set_flags, branchReg, branchLink, memRead;
  logic [1:0] fwdEn;
  logic [2:0] ALU_cntrl;
  logic memToReg_EX, memWrite_EX, memRead_EX, branchLink_EX, RegWrite_EX;
  logic [4:0] targetReg_EX;
  logic [DATA_W-1:0] toDataMem, ALU_B, rd2_EX, memData;
  logic memToReg_MEM, memWrite_MEM, memRead_MEM, branchLink_MEM, RegWrite_MEM;
  logic [4:0] targetReg_MEM;
  logic [DATA_W-1:0] toDataMem_MEM, ALU_B_MEM, rd2_MEM, memData_MEM;

  always #5 clk = ~clk;

  ctrl_decode_exmem #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .sign(sign),
    .uncondBr(uncondBr), .branch(branch), .Reg2Loc(Reg2Loc), .ALU_Src(ALU_Src),
    .RegWrite(RegWrite), .ALU_SH(ALU_SH), .Imm(Imm), .memToReg(memToReg),
    .memWrite(memWrite), .shiftDirn(shiftDirn), .ALU_on(ALU_on),
    .set_flags(set_flags), .branchReg(branchReg), .branchLink(branchLink),
    .memRead(memRead), .fwdEn(fwdEn), .ALU_cntrl(ALU_cntrl),
    .memToReg_EX(memToReg_EX), .memWrite_EX(memWrite_EX), .memRead_EX(memRead_EX),
    .branchLink_EX(branchLink_EX), .RegWrite_EX(RegWrite_EX),
    .targetReg_EX(targetReg_EX), .toDataMem(toDataMem), .ALU_B(ALU_B),
    .rd2_EX(rd2_EX), .memData(memData),
    .memToReg_MEM(memToReg_MEM), .memWrite_MEM(memWrite_MEM),
    .memRead_MEM(memRead_MEM), .branchLink_MEM(branchLink_MEM),
    .RegWrite_MEM(RegWrite_MEM), .targetReg_MEM(targetReg_MEM),
    .toDataMem_MEM(toDataMem_MEM), .ALU_B_MEM(ALU_B_MEM), .rd2_MEM(rd2_MEM),
    .memData_MEM(memData_MEM)
  );

  logic [14:0] obs_ctl;
  logic [PW-1:0] obs_pipe, in_pipe;
  assign obs_ctl = {uncondBr, branch, Reg2Loc, ALU_Src, RegWrite, ALU_SH, Imm,
                    memToReg, memWrite, shiftDirn, ALU_on, set_flags, branchReg,
                    branchLink, memRead};
  assign obs_pipe = {memToReg_MEM, memWrite_MEM, memRead_MEM, branchLink_MEM,
                     RegWrite_MEM, targetReg_MEM, toDataMem_MEM, ALU_B_MEM,
                     rd2_MEM, memData_MEM};
  assign in_pipe = {memToReg_EX, memWrite_EX, memRead_EX, branchLink_EX,
                    RegWrite_EX, targetReg_EX, toDataMem, ALU_B, rd2_EX, memData};

  // Instruction table, longest prefix first; first match is the decoded instruction.
  typedef struct {
    int          len;
    logic [10:0] pat;
    logic [14:0] ctl;
    logic [1:0]  fwd;
    logic [2:0]  alu;
    bit          sign_alu;
  } entry_t;
  entry_t tbl[14];

  int n_checks = 0;
  int n_pass = 0;
  logic [PW-1:0] exp_pipe;

  task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic void model(input logic [10:0] op, input logic s,
                                output logic [14:0] ctl, output logic [1:0] fwd,
                                output logic [2:0] alu);
    ctl = '0; fwd = '0; alu = '0;
    for (int i = 0; i < 14; i++) begin
      if ((op >> (11 - tbl[i].len)) == tbl[i].pat) begin
        ctl = tbl[i].ctl;
        fwd = tbl[i].fwd;
        alu = tbl[i].sign_alu ? (s ? 3'b011 : 3'b010) : tbl[i].alu;
        return;
      end
    end
  endfunction

  task automatic chk_decode(input string tag);
    logic [14:0] c;
    logic [1:0] f;
    logic [2:0] a;
    model(opcode, sign, c, f, a);
    chk({tag, ".ctl"}, 300'(obs_ctl), 300'(c));
    chk({tag, ".fwd"}, 300'(fwdEn), 300'(f));
    chk({tag, ".alu"}, 300'(ALU_cntrl), 300'(a));
  endtask

  task automatic drive_ex(input logic [PW-1:0] v);
    {memToReg_EX, memWrite_EX, memRead_EX, branchLink_EX, RegWrite_EX,
     targetReg_EX, toDataMem, ALU_B, rd2_EX, memData} = v;
  endtask

  initial begin
    tbl[0]  = '{11, 11'b10101011000, R2L|RW|ON|SF, 2'b11, 3'b010, 0};
    tbl[1]  = '{11, 11'b11101011000, R2L|RW|ON|SF, 2'b11, 3'b011, 0};
    tbl[2]  = '{11, 11'b10001010000, R2L|RW|ON, 2'b11, 3'b100, 0};
    tbl[3]  = '{11, 11'b11001010000, R2L|RW|ON, 2'b11, 3'b110, 0};
    tbl[4]  = '{11, 11'b11010011011, RW|SH, 2'b00, 3'b000, 0};
    tbl[5]  = '{11, 11'b11010011010, RW|SH|DIR, 2'b00, 3'b000, 0};
    tbl[6]  = '{11, 11'b11111000010, SRC|RW|M2R|MRD|ON, 2'b00, 3'b000, 1};
    tbl[7]  = '{11, 11'b11111000000, SRC|MW|ON, 2'b00, 3'b000, 1};
    tbl[8]  = '{11, 11'b11010110000, BRN|BRR, 2'b00, 3'b000, 0};
    tbl[9]  = '{10, 11'b01001000100, SRC|IMM|RW|ON, 2'b10, 3'b010, 0};
    tbl[10] = '{8, 11'b00010110100, BRN|ON, 2'b00, 3'b000, 0};
    tbl[11] = '{8, 11'b00001010100, BRN, 2'b00, 3'b000, 0};
    tbl[12] = '{6, 11'b00000000101, BRN|UNC, 2'b00, 3'b000, 0};
    tbl[13] = '{6, 11'b00000100101, BRN|UNC|BL|RW|ON, 2'b00, 3'b000, 0};

    rst = 1'b0;
    opcode = 11'b10101011000;
    sign = 1'b0;
    drive_ex('0);
    #2;
    chk("reset.pipe", 300'(obs_pipe), 300'(0));
    chk("reset.ctl", 300'(obs_ctl), 300'(0));
    chk("reset.fwd_alu", 300'({fwdEn, ALU_cntrl}), 300'(0));

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("adds.ctl", 300'(obs_ctl), 300'(R2L|RW|ON|SF));
    chk("adds.fwd_alu", 300'({fwdEn, ALU_cntrl}), 300'(5'b11_010));
    opcode = 11'b11111000010; sign = 1'b1; #1;
    chk("ldur_neg.ctl", 300'(obs_ctl), 300'(SRC|RW|M2R|MRD|ON));
    chk("ldur_neg.alu", 300'(ALU_cntrl), 300'(3'b011));
    sign = 1'b0; #1;
    chk("ldur_pos.alu", 300'(ALU_cntrl), 300'(3'b010));
    opcode = 11'b10010100000; #1;
    chk("bl.ctl", 300'(obs_ctl), 300'(BRN|UNC|BL|RW|ON));
    chk("bl.alu", 300'(ALU_cntrl), 300'(3'b000));
    opcode = 11'b10110100101; #1;
    chk("cbz.ctl", 300'(obs_ctl), 300'(BRN|ON));
    opcode = 11'b11111111111; #1;
    chk("nop.ctl", 300'(obs_ctl), 300'(0));
    chk("nop.fwd_alu", 300'({fwdEn, ALU_cntrl}), 300'(0));
    opcode = 11'b11010011010; #1;
    chk("lsr.ctl", 300'(obs_ctl), 300'(RW|SH|DIR));
    chk("lsr.fwd_alu", 300'({fwdEn, ALU_cntrl}), 300'(0));

    drive_ex('0);
    RegWrite_EX = 1'b1;
    targetReg_EX = 5'd7;
    toDataMem = 64'h1234;
    #1;
    chk("capture.before", 300'(obs_pipe), 300'(0));
    @(posedge clk); #1;
    chk("capture.data", 300'(toDataMem_MEM), 300'(64'h1234));
    chk("capture.rw_tgt", 300'({RegWrite_MEM, targetReg_MEM}), 300'({1'b1, 5'd7}));
    exp_pipe = in_pipe;

    for (int it = 0; it < 200; it++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) < 14) begin
        int k;
        k = $urandom_range(0, 13);
        opcode = (tbl[k].pat << (11 - tbl[k].len)) |
                 (11'($urandom) & ((11'd1 << (11 - tbl[k].len)) - 11'd1));
      end else begin
        opcode = 11'($urandom);
      end
      sign = 1'($urandom);
      drive_ex({10'($urandom), 32'($urandom), 32'($urandom), 32'($urandom),
                32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom),
                32'($urandom)});
      #1;
      chk_decode("rand.dec");
      chk("rand.hold", 300'(obs_pipe), 300'(exp_pipe));
      @(posedge clk); #1;
      exp_pipe = in_pipe;
      chk("rand.cap", 300'(obs_pipe), 300'(exp_pipe));
    end

    @(negedge clk);
    drive_ex('1);
    opcode = 11'b10101011000;
    @(posedge clk); #2;
    chk("prereset.pipe", 300'(obs_pipe), 300'(in_pipe));
    rst = 1'b0; #1;
    chk("async_reset.pipe", 300'(obs_pipe), 300'(0));
    chk("async_reset.ctl", 300'({obs_ctl, fwdEn, ALU_cntrl}), 300'(0));
    @(negedge clk);
    rst = 1'b1;
    drive_ex({10'h2a5, 64'hdead_beef_0000_0001, 64'h2, 64'h3, 64'h4});
    #1;
    chk("post_reset.discard", 300'(obs_pipe), 300'(0));
    @(posedge clk); #1;
    chk("post_reset.cap", 300'(obs_pipe),
        300'({10'h2a5, 64'hdead_beef_0000_0001, 64'h2, 64'h3, 64'h4}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
